// File: rtl/length_extraction.sv
// length_extraction: finds word boundaries in the packed compressed stream.
// 128-bit chunks go into a 256-bit MSB-aligned buffer. Each output beat
// decodes two words from the top of the buffer. After the second beat of a
// line, the compressor's padding up to the next 128-bit line boundary is
// dropped.
//
// Handshake (both directions): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds its valid and data stable
// until that edge. o_ready depends only on registered state. o_valid/outputs
// hold while o_valid & !i_ready.
module length_extraction #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [127:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [2:0]   o_encoded1,
  output logic [2:0]   o_encoded2,
  output logic [5:0]   o_length1,
  output logic [5:0]   o_length2,
  output logic [6:0]   o_total_length,
  output logic [31:0]  o_body1,
  output logic [31:0]  o_body2,
  output logic         o_last,
  output logic         o_error
);

  localparam int PAIRS_PER_LINE = CACHE_LINE / WORD_SIZE;
  localparam logic [1:0] LAST_PAIR = 2'(PAIRS_PER_LINE - 1);

  // One decoded word. For the illegal prefix, len is 4: that is how many bits
  // must be valid before the prefix can be trusted.
  typedef struct packed {
    logic [2:0]  enc;
    logic [5:0]  len;
    logic [31:0] body;
    logic        illegal;
  } dec_t;

  // Decodes the prefix at the top of a 36-bit window. The body is returned
  // right-aligned and zero-extended.
  function automatic dec_t decode_word(input logic [35:0] t);
    dec_t        d;
    logic [31:0] raw;
    logic [5:0]  blen;
    d    = '0;
    raw  = t[33:2];
    blen = 6'd0;
    case (t[35:34])
      2'b00: begin d.enc = 3'd0; d.len = 6'd2;  blen = 6'd0;  end
      2'b01: begin d.enc = 3'd1; d.len = 6'd34; blen = 6'd32; end
      2'b10: begin d.enc = 3'd2; d.len = 6'd6;  blen = 6'd4;  end
      default: begin
        raw = t[31:0];
        case (t[33:32])
          2'b00:   begin d.enc = 3'd3; d.len = 6'd24; blen = 6'd20; end
          2'b01:   begin d.enc = 3'd4; d.len = 6'd12; blen = 6'd8;  end
          2'b10:   begin d.enc = 3'd5; d.len = 6'd16; blen = 6'd12; end
          default: begin d.illegal = 1'b1; d.len = 6'd4; blen = 6'd0; end
        endcase
      end
    endcase
    d.body = (blen == 6'd0) ? 32'd0 : (raw >> (6'd32 - blen));
    return d;
  endfunction

  // Registered state
  logic [255:0] r_buf;
  logic [8:0]   r_count;
  logic [6:0]   r_offset;
  logic [1:0]   r_pair_cnt;
  logic [7:0]   r_pad_pend;
  logic         r_error;
  logic         r_valid;
  logic [2:0]   r_enc1, r_enc2;
  logic [5:0]   r_len1, r_len2;
  logic [6:0]   r_total;
  logic [31:0]  r_body1, r_body2;
  logic         r_last;

  // Combinational decode / consumption
  dec_t         w_d1, w_d2;
  logic [35:0]  w_top2;
  logic [8:0]   w_need;
  logic         w_ill1, w_ill2, w_fits, w_out_free, w_active;
  logic         w_load, w_err_set, w_is_last, w_accept;
  logic [8:0]   w_consumed, w_after, w_drop, w_shift, w_cnt_post, w_cnt_next;
  logic [6:0]   w_off_sum, w_pad;
  logic [7:0]   w_pad_req, w_pend_next;
  logic [255:0] w_ins, w_buf_next;

  assign w_d1   = decode_word(r_buf[255:220]);
  assign w_top2 = r_buf[9'd255 - {3'd0, w_d1.len} -: 36];
  assign w_d2   = decode_word(w_top2);
  assign w_need = {3'd0, w_d1.len} + {3'd0, w_d2.len};

  // An illegal prefix only counts once all four of its bits are valid data.
  assign w_ill1 = w_d1.illegal && (r_count >= 9'd4);
  assign w_ill2 = !w_d1.illegal && w_d2.illegal &&
                  (r_count >= ({3'd0, w_d1.len} + 9'd4));
  assign w_fits = r_count >= w_need;

  assign w_out_free = !r_valid || i_ready;
  assign w_active   = !r_error && (r_pad_pend == 8'd0);
  assign w_load     = w_active && w_out_free && w_fits &&
                      !w_d1.illegal && !w_d2.illegal;
  assign w_err_set  = w_active && w_out_free && (w_ill1 || w_ill2);
  assign w_is_last  = (r_pair_cnt == LAST_PAIR);

  assign w_consumed = w_load ? w_need : 9'd0;
  assign w_after    = r_count - w_consumed;
  assign w_off_sum  = r_offset + w_need[6:0];
  assign w_pad      = 7'd0 - w_off_sum;

  // Padding to drop: fresh pad after the last pair, otherwise any leftover.
  always_comb begin
    w_pad_req = 8'd0;
    if (w_load && w_is_last)
      w_pad_req = {1'b0, w_pad};
    else if (!r_error && (r_pad_pend != 8'd0))
      w_pad_req = r_pad_pend;
  end

  assign w_drop      = ({1'b0, w_pad_req} > w_after) ? w_after : {1'b0, w_pad_req};
  assign w_pend_next = w_pad_req - w_drop[7:0];
  assign w_shift     = w_consumed + w_drop;
  assign w_cnt_post  = r_count - w_shift;

  assign o_ready  = (r_count <= 9'd128) && !r_error;
  assign w_accept = i_valid && o_ready;

  // A new chunk goes directly below the bits that survive this edge.
  assign w_ins      = {i_data, 128'd0} >> w_cnt_post;
  assign w_buf_next = (r_buf << w_shift) | (w_accept ? w_ins : 256'd0);
  assign w_cnt_next = w_cnt_post + (w_accept ? 9'd128 : 9'd0);

  // Buffer, line tracking and the sticky error flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_buf      <= '0;
      r_count    <= '0;
      r_offset   <= '0;
      r_pair_cnt <= '0;
      r_pad_pend <= '0;
      r_error    <= 1'b0;
    end else begin
      r_buf      <= w_buf_next;
      r_count    <= w_cnt_next;
      r_pad_pend <= w_pend_next;
      if (w_err_set)
        r_error <= 1'b1;
      if (w_load) begin
        if (w_is_last) begin
          r_offset   <= 7'd0;
          r_pair_cnt <= 2'd0;
        end else begin
          r_offset   <= w_off_sum;
          r_pair_cnt <= r_pair_cnt + 2'd1;
        end
      end
    end
  end

  // Output pair register: loads on a decodable pair, otherwise holds.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_enc1  <= '0;
      r_enc2  <= '0;
      r_len1  <= '0;
      r_len2  <= '0;
      r_total <= '0;
      r_body1 <= '0;
      r_body2 <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_enc1  <= w_d1.enc;
      r_enc2  <= w_d2.enc;
      r_len1  <= w_d1.len;
      r_len2  <= w_d2.len;
      r_total <= w_need[6:0];
      r_body1 <= w_d1.body;
      r_body2 <= w_d2.body;
      r_last  <= w_is_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid        = r_valid;
  assign o_encoded1     = r_enc1;
  assign o_encoded2     = r_enc2;
  assign o_length1      = r_len1;
  assign o_length2      = r_len2;
  assign o_total_length = r_total;
  assign o_body1        = r_body1;
  assign o_body2        = r_body2;
  assign o_last         = r_last;
  assign o_error        = r_error;

endmodule

// File: tb/tb_length_extraction.sv
// Bench for length_extraction. Builds lines word by word from the code
// table and packs them into 128-bit chunks. As each pair is built, its
// expected beat goes into a queue. A monitor pops the queue on every
// output handshake.
module tb_length_extraction;

  logic         clk;
  logic         i_reset;
  logic [127:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         o_valid;
  logic         i_ready;
  logic [2:0]   o_encoded1, o_encoded2;
  logic [5:0]   o_length1, o_length2;
  logic [6:0]   o_total_length;
  logic [31:0]  o_body1, o_body2;
  logic         o_last;
  logic         o_error;

  length_extraction #(.CACHE_LINE(128), .WORD_SIZE(64)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_encoded1     (o_encoded1),
    .o_encoded2     (o_encoded2),
    .o_length1      (o_length1),
    .o_length2      (o_length2),
    .o_total_length (o_total_length),
    .o_body1        (o_body1),
    .o_body2        (o_body2),
    .o_last         (o_last),
    .o_error        (o_error)
  );

  localparam int W = 90;

  logic [W-1:0]   exp_q[$];
  logic [127:0]   chunk_q[$];
  bit             stream_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  int             widx = 0;
  logic [2:0]     pe;
  logic [5:0]     pl;
  logic [31:0]    pb;
  bit             feed_en = 0;
  bit             stall = 0;
  bit             rnd_rdy = 0;
  logic [W-1:0]   held_val;
  bit             held = 0;
  logic [W-1:0]   obs;

  assign obs = {o_encoded1, o_encoded2, o_length1, o_length2, o_total_length,
                o_body1, o_body2, o_last};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Appends one word to the stream. Every second word completes an expected pair.
  task automatic add_word(input int enc, input logic [31:0] body);
    logic [3:0]  pfx;
    int          plen, blen, len;
    logic [32:0] mask;
    logic [31:0] bm;
    case (enc)
      0: begin pfx = 4'b0000; plen = 2; blen = 0;  end
      1: begin pfx = 4'b0100; plen = 2; blen = 32; end
      2: begin pfx = 4'b1000; plen = 2; blen = 4;  end
      3: begin pfx = 4'b1100; plen = 4; blen = 20; end
      4: begin pfx = 4'b1101; plen = 4; blen = 8;  end
      default: begin pfx = 4'b1110; plen = 4; blen = 12; end
    endcase
    mask = (33'd1 << blen) - 33'd1;
    bm = body & mask[31:0];
    for (int i = 0; i < plen; i++) stream_q.push_back(pfx[3-i]);
    for (int i = blen - 1; i >= 0; i--) stream_q.push_back(bm[i]);
    len = plen + blen;
    if (widx % 2 == 0) begin
      pe = 3'(enc); pl = 6'(len); pb = bm;
    end else begin
      exp_q.push_back({pe, 3'(enc), pl, 6'(len), 7'(int'(pl) + len), pb, bm, (widx == 3)});
    end
    widx = (widx + 1) % 4;
  endtask

  // Zero-pads the stream to a line boundary and queues its chunks.
  task automatic end_line();
    logic [127:0] c;
    while (stream_q.size() % 128 != 0) stream_q.push_back(1'b0);
    while (stream_q.size() >= 128) begin
      for (int i = 127; i >= 0; i--) c[i] = stream_q.pop_front();
      chunk_q.push_back(c);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || chunk_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    assert (exp_q.size() == 0 && chunk_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s drain: pairs_left=%0d chunks_left=%0d expected 0/0", tag, exp_q.size(), chunk_q.size());
    end
  endtask

  task automatic clear_all();
    exp_q.delete();
    chunk_q.delete();
    stream_q.delete();
    widx = 0;
  endtask

  // Chunk driver: presents the head of chunk_q, pops it on acceptance.
  initial begin
    bit acc;
    i_valid = 1'b0;
    i_data  = '0;
    forever begin
      @(negedge clk);
      if (feed_en && chunk_q.size() > 0) begin
        i_valid = 1'b1;
        i_data  = chunk_q[0];
      end else begin
        i_valid = 1'b0;
        i_data  = '0;
      end
      #1;
      acc = i_valid && o_ready && !i_reset;
      @(posedge clk);
      if (acc && chunk_q.size() > 0) void'(chunk_q.pop_front());
    end
  end

  // Downstream ready driver
  initial begin
    i_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) i_ready = 1'b0;
      else if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
      else i_ready = 1'b1;
    end
  end

  // Monitor: checks stability while stalled, scoreboard on each handshake.
  always @(negedge clk) begin
    #2;
    if (!i_reset && o_valid) begin
      if (held) begin
        n_vec++;
        assert (obs === held_val) else begin
          n_err++;
          $error("FAIL hold_stable observed=%h expected=%h", obs, held_val);
        end
      end
      if (i_ready) begin
        held = 0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $error("FAIL unexpected_pair observed=%h expected=none", obs);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          assert (obs === e) else begin
            n_err++;
            $error("FAIL pair observed=%h expected=%h", obs, e);
          end
        end
      end else begin
        held = 1;
        held_val = obs;
      end
    end else begin
      held = 0;
    end
  end

  initial begin
    int c;
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", 128'(o_valid), 128'd0);
    check("reset_ready", 128'(o_ready), 128'd1);
    check("reset_error", 128'(o_error), 128'd0);
    check("reset_data", 128'(obs), 128'd0);
    @(negedge clk);
    i_reset = 1'b0;
    feed_en = 1;

    // All-zero line: two pairs of 2/2; the remaining 120 bits are padding
    for (int i = 0; i < 4; i++) add_word(0, 32'd0);
    end_line();
    wait_drain("zero_line", 100);
    check("zero_idle_valid", 128'(o_valid), 128'd0);
    check("zero_idle_ready", 128'(o_ready), 128'd1);

    // Literal line spanning two chunks
    add_word(1, 32'hAAAA_5555);
    add_word(1, 32'hBBBB_0001);
    add_word(1, 32'hCCCC_1234);
    add_word(1, 32'hDDDD_FFFF);
    end_line();
    wait_drain("literal_line", 100);

    // Mixed codes
    add_word(2, 32'h3);
    add_word(3, 32'h5ABCD);
    add_word(4, 32'h7F);
    add_word(5, 32'h9C3);
    end_line();
    wait_drain("mixed_line", 100);

    // Back-pressure: stall with o_valid high; o_ready must drop, nothing lost
    stall = 1;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 4; k++) add_word(1, $urandom());
      end_line();
    end
    c = 0;
    while (!o_valid && c < 50) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    #3;
    check("bp_valid_held", 128'(o_valid), 128'd1);
    check("bp_ready_low", 128'(o_ready), 128'd0);
    stall = 0;
    wait_drain("backpressure", 300);

    // Random lines under random downstream readiness
    rnd_rdy = 1;
    for (int l = 0; l < 16; l++) begin
      for (int k = 0; k < 4; k++) add_word($urandom_range(0, 5), $urandom());
      end_line();
    end
    wait_drain("random_lines", 2000);
    rnd_rdy = 0;

    // Async reset mid-line with a held output pair
    stall = 1;
    add_word(4, 32'h11); add_word(3, 32'hFFFFF);
    add_word(1, 32'h1); add_word(2, 32'h8);
    end_line();
    c = 0;
    while (!o_valid && c < 50) begin @(negedge clk); c++; end
    check("pre_reset_valid", 128'(o_valid), 128'd1);
    @(posedge clk);
    #3;
    i_reset = 1'b1;
    feed_en = 0;
    #1;
    check("midreset_valid", 128'(o_valid), 128'd0);
    check("midreset_data", 128'(obs), 128'd0);
    check("midreset_ready", 128'(o_ready), 128'd1);
    clear_all();
    stall = 0;
    @(negedge clk);
    i_reset = 1'b0;
    feed_en = 1;

    // Recovery after reset: buffer must be clean
    add_word(2, 32'hA); add_word(0, 32'd0);
    add_word(5, 32'h123); add_word(1, 32'hCAFE_BEEF);
    end_line();
    wait_drain("post_reset_line", 100);

    // Illegal prefix as word 2
    stream_q.push_back(1'b0); stream_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) stream_q.push_back(1'b1);
    end_line();
    repeat (10) @(negedge clk);
    #3;
    check("err_flag", 128'(o_error), 128'd1);
    check("err_valid", 128'(o_valid), 128'd0);
    check("err_ready", 128'(o_ready), 128'd0);
    @(posedge clk);
    #3;
    i_reset = 1'b1;
    #1;
    check("err_reset_error", 128'(o_error), 128'd0);
    check("err_reset_ready", 128'(o_ready), 128'd1);
    check("err_reset_valid", 128'(o_valid), 128'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/length_extraction.md
Name: length_extraction

Overview:
- Decompression-side counterpart of the compressor's length generation.
- Takes the packed compressed bitstream in 128-bit chunks and locates the word boundaries.
- Each output beat carries one word pair: two decoded code types, two lengths, two body fields, and an end-of-line flag.
- Feeds the dictionary/reconstruction stage of the decompressor.

Parameters:
- CACHE_LINE, 128: uncompressed line width in bits. Words per line = CACHE_LINE/32 = 4, so each line is 2 pair-beats.
- WORD_SIZE, 64: pair width per beat. Each word is WORD_SIZE/2 = 32 bits.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  128  compressed chunk. MSB is the earliest stream bit.
- i_valid  in  1  i_data valid
- o_ready  out  1  chunk accepted on an edge where i_valid & o_ready
- o_valid  out  1  output pair valid
- i_ready  in  1  downstream accepts the pair on an edge where o_valid & i_ready
- o_encoded1  out  3  code type of word 1 (earlier word)
- o_encoded2  out  3  code type of word 2
- o_length1  out  6  total bits of word 1, prefix included
- o_length2  out  6  total bits of word 2
- o_total_length  out  7  o_length1 + o_length2
- o_body1  out  32  word 1 bits following its prefix, right-aligned, zero-extended
- o_body2  out  32  same for word 2
- o_last  out  1  pair holds the final two words of a line
- o_error  out  1  sticky illegal-prefix flag

Behaviour:
- Reset (async, any time, including mid-line): buffer cleared to all-zero, count=0, line offset=0, pair counter=0.
  - Outputs: o_valid=0, o_ready=1, o_error=0; all data outputs 0.
- Code table (prefix -> encoded, total length):
  - 00 -> 0, 2 (zzzz)
  - 01 -> 1, 34 (xxxx: 32 literal bits)
  - 10 -> 2, 6 (mmmm: 4-bit index)
  - 1100 -> 3, 24 (mmxx: idx4 + 16 bits)
  - 1101 -> 4, 12 (zzzx: 8 bits)
  - 1110 -> 5, 16 (mmmx: idx4 + 8 bits)
  - 1111 -> illegal
- Buffer: 256-bit MSB-aligned shift register plus a 9-bit valid-bit count (0..256).
  - Bits below count are always zero. Decode may read them safely, because a zero-filled prefix never yields a length that fits in count.
- o_ready = (count <= 128), from registered state only.
- Accepted chunk is written directly below the post-consumption valid bits.
  - Same-cycle accept and consume: new_count = count - consumed - pad + 128.
- Decode (combinational from buffer top):
  - len1 comes from bits [255:252].
  - len2 comes from the 4 bits starting at offset len1.
  - The pair is decodable when count >= len1 + len2 (max 68).
- Output register:
  - Loads when the pair is decodable and (o_valid==0 or i_ready==1).
  - The buffer shifts left by len1+len2 on the same edge and zero-fills.
  - Latency: a chunk accepted at edge E0 can produce o_valid after edge E1.
- Output hold: while o_valid & !i_ready, all outputs stay stable and no consumption occurs.
- Line boundary:
  - A 2-bit pair counter tracks beats; o_last=1 on the second pair of each line.
  - A 7-bit line offset accumulates consumed bits mod 128.
  - When the o_last pair is loaded, the padding is also dropped: pad = (128 - offset) mod 128. Each compressed line is padded to a 128-bit boundary by the compressor.
  - After the drop, offset and pair counter reset to 0.
  - If pad > count - consumed, the drop completes against the next chunk: a pending-pad register holds the remainder and is applied before any decode.
- Illegal prefix 1111 in either decodable word:
  - o_error sets; o_valid is not raised for that pair.
  - The block stops consuming and holds o_ready=0 until reset.
- o_total_length width: max 68, so it cannot overflow 7 bits.

Test Plan:
- All-zero line: chunk 0x0000...0.
  - Expected: two pairs, encoded 0/0, length 2/2, total 4, o_last=0 then 1.
  - Remaining 120 bits are dropped; count=0 afterwards.
- Literal line: four xxxx words, bodies A,B,C,D (136 bits over two chunks).
  - Expected: pair1 lengths 34/34, bodies A/B; pair2 needs chunk 2 and gives bodies C/D with o_last=1.
  - Pad drop is 120 bits.
- Mixed codes 10+0011, 1100+5+ABCD, 1101+7F, 1110+9+C3.
  - Expected: encoded 2/3, 4/5; lengths 6/24, 12/16; o_body1=0x3, o_body2=0x5ABCD.
- Back-pressure: hold i_ready=0 for 5 cycles with o_valid=1.
  - Expected: outputs stable; o_ready drops once count>128; no chunk is lost.
- Simultaneous accept and consume with count=128.
  - Expected: correct concatenation; the next pair matches the golden model.
- Prefix 1111 as word 2.
  - Expected: o_error=1, o_valid stays 0, o_ready=0.
  - Async i_reset mid-cycle clears all outputs immediately.
